// File: rtl/word_packer_pkg.sv
// Shared byte/word geometry for the byte<->word conversion blocks.
// Lane ordering: the first byte of a word occupies bits [31:24], the
// fourth occupies [7:0]; the word-to-byte splitter uses the same rule.
package word_packer_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam int IDX_W          = 2;
   localparam int CNT_W          = IDX_W + 1;

   // Top bit of byte lane k (lane 0 is the first byte, at the MSB end).
   function automatic int lane_hi(input int k);
      return WORD_W - 1 - BYTE_W * k;
   endfunction

endpackage

// File: rtl/word_packer_byte_lane_decoder.sv
// Purpose: turn the current slot index into a one-hot byte-lane enable.
// Ports:   idx (slot 0..3) -> lane_en (bit k set when idx == k).
// Latency: purely combinational.
module word_packer_byte_lane_decoder
   import word_packer_pkg::*;
(
   input  logic [IDX_W-1:0]          idx,
   output logic [BYTES_PER_WORD-1:0] lane_en
);

   always_comb begin
      lane_en      = '0;
      lane_en[idx] = 1'b1;
   end

endmodule

// File: rtl/word_packer.sv
// Purpose: pack a byte stream into 32-bit words, first byte in the MSB lane;
//          in_last closes a partial word, unfilled low lanes read as zero.
// Ports:   clk/reset_n; in_valid/in_ready/in_data/in_last byte side;
//          out_valid/out_ready/out_data/out_bytes word side; busy status.
// Latency: completing byte accepted in cycle N -> out_valid in cycle N+1.
// Backpressure: one output register; in_ready = ~out_valid | out_ready.
module word_packer
   import word_packer_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_bytes,
   output logic              busy
);

   logic [IDX_W-1:0]          idx;
   logic [WORD_W-1:0]         acc;
   logic [WORD_W-1:0]         merged;
   logic [BYTES_PER_WORD-1:0] lane_en;
   logic                      byte_take;
   logic                      word_take;
   logic                      complete;

   // A byte can enter whenever the output register is empty or being
   // drained this cycle, so a new word can replace the old one with no bubble.
   assign in_ready  = ~out_valid | out_ready;
   assign byte_take = in_valid & in_ready;
   assign word_take = out_valid & out_ready;
   assign complete  = byte_take & ((idx == IDX_W'(BYTES_PER_WORD - 1)) | in_last);
   assign busy      = (idx != '0) | out_valid;

   word_packer_byte_lane_decoder u_lane_dec (
      .idx     (idx),
      .lane_en (lane_en)
   );

   // Accumulator with the incoming byte dropped into its lane.
   for (genvar i = 0; i < BYTES_PER_WORD; i++) begin : g_lane
      localparam int HI = lane_hi(i);
      assign merged[HI -: BYTE_W] = lane_en[i] ? in_data : acc[HI -: BYTE_W];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx       <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_bytes <= '0;
      end else if (complete) begin
         // Clearing acc here is what keeps lanes beyond a partial count zero.
         out_data  <= merged;
         out_bytes <= {1'b0, idx} + CNT_W'(1);
         out_valid <= 1'b1;
         acc       <= '0;
         idx       <= '0;
      end else begin
         if (byte_take) begin
            acc <= merged;
            idx <= idx + IDX_W'(1);
         end
         if (word_take) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_word_packer.sv
// Purpose: self-checking bench for word_packer (vector table + scoreboard).
// Ports:   none; drives all DUT ports, 10 ns clock.
// Checks:  reset state, packing, partial words, stall, back-to-back, reset.
module tb_word_packer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [2:0]  out_bytes;
   logic        busy;

   word_packer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bytes (out_bytes),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        l;
      logic        v;
      logic [31:0] w;
      logic [2:0]  n;
   } vec_t;

   typedef struct {
      logic [31:0] w;
      logic [2:0]  n;
   } exp_t;

   vec_t vec [15];
   exp_t sb_q [$];
   int   pop_cyc [$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one byte; wait (bounded) until it is accepted. If it completes a
   // word, its expected result goes onto the scoreboard as it is taken.
   task automatic send(input logic [7:0] d, input logic l, input logic v,
                       input logic [31:0] w, input logic [2:0] n);
      bit taken;
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      taken    = 1'b0;
      for (int t = 0; t < 50 && !taken; t++) begin
         @(negedge clk);
         if (in_ready) taken = 1'b1;
      end
      if (!taken) begin
         chk("send_timeout", 32'(taken), 32'd1);
      end else if (v) begin
         e.w = w;
         e.n = n;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   wait_cnt;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b1;

      vec[0]  = '{8'h12, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[1]  = '{8'h34, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[2]  = '{8'h56, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[3]  = '{8'h78, 1'b0, 1'b1, 32'h12345678, 3'd4};
      vec[4]  = '{8'hAA, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[5]  = '{8'hBB, 1'b1, 1'b1, 32'hAABB0000, 3'd2};
      vec[6]  = '{8'hFF, 1'b1, 1'b1, 32'hFF000000, 3'd1};
      vec[7]  = '{8'h00, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[8]  = '{8'h01, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[9]  = '{8'h02, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[10] = '{8'h03, 1'b0, 1'b1, 32'h00010203, 3'd4};
      vec[11] = '{8'h04, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[12] = '{8'h05, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[13] = '{8'h06, 1'b0, 1'b0, 32'h0,        3'd0};
      vec[14] = '{8'h07, 1'b0, 1'b1, 32'h04050607, 3'd4};

      // Output monitor: a word is taken at the next rising edge whenever
      // out_valid && out_ready is seen here; compare it with the scoreboard.
      fork
         forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_word", out_data, 32'hXXXXXXXX);
               end else begin
                  e = sb_q.pop_front();
                  chk("out_data", out_data, e.w);
                  chk("out_bytes", 32'(out_bytes), 32'(e.n));
                  pop_cyc.push_back(cyc);
               end
            end
         end
      join_none

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_bytes", 32'(out_bytes), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Table-driven stream: full word, partial, single byte, back-to-back.
      for (int i = 0; i < 15; i++) begin
         send(vec[i].d, vec[i].l, vec[i].v, vec[i].w, vec[i].n);
         if (i == 2) chk("busy_mid_word", 32'(busy), 32'd1);
         if (i == 3) begin
            // Completing byte taken at the last edge: word visible now.
            chk("latency_out_valid", 32'(out_valid), 32'd1);
            chk("full_in_ready", 32'(in_ready), 32'd1);
         end
      end
      @(negedge clk);
      chk("b2b_pop_count", 32'(pop_cyc.size()), 32'd5);
      if (pop_cyc.size() >= 2)
         chk("b2b_word_spacing", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]), 32'd4);

      // Backpressure: stall DEADBEEF for 5 cycles while 01..04 wait to enter.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(8'hDE, 1'b0, 1'b0, 32'h0, 3'd0);
      send(8'hAD, 1'b0, 1'b0, 32'h0, 3'd0);
      send(8'hBE, 1'b0, 1'b0, 32'h0, 3'd0);
      send(8'hEF, 1'b0, 1'b1, 32'hDEADBEEF, 3'd4);
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
               chk("stall_out_data", out_data, 32'hDEADBEEF);
               chk("stall_out_bytes", 32'(out_bytes), 32'd4);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
         begin
            send(8'h01, 1'b0, 1'b0, 32'h0, 3'd0);
            send(8'h02, 1'b0, 1'b0, 32'h0, 3'd0);
            send(8'h03, 1'b0, 1'b0, 32'h0, 3'd0);
            send(8'h04, 1'b0, 1'b1, 32'h01020304, 3'd4);
         end
      join

      // Reset mid-word discards 11,22; next word starts clean.
      send(8'h11, 1'b0, 1'b0, 32'h0, 3'd0);
      send(8'h22, 1'b0, 1'b0, 32'h0, 3'd0);
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      send(8'h33, 1'b0, 1'b0, 32'h0, 3'd0);
      send(8'h44, 1'b0, 1'b0, 32'h0, 3'd0);
      send(8'h55, 1'b0, 1'b0, 32'h0, 3'd0);
      send(8'h66, 1'b0, 1'b1, 32'h33445566, 3'd4);

      // Drain the scoreboard within a bounded number of cycles.
      wait_cnt = 0;
      while (sb_q.size() != 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      chk("total_words", 32'(pop_cyc.size()), 32'd8);
      chk("idle_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
